// File: rtl/driver_matriz_pkg.sv
// Shared types and constants for the LED matrix scan driver.
package driver_matriz_pkg;

    typedef enum logic {
        APAGADO = 1'b0,
        ACESO   = 1'b1
    } estado_t;

    localparam int LINHAS_PADRAO       = 8;
    localparam int COLUNAS_PADRAO      = 8;
    localparam int DIV_BITS_PADRAO     = 8;
    localparam int BRILHO_BITS_PADRAO  = 4;
    localparam int BLANK_CICLOS_PADRAO = 2;
    localparam int ATIVO_ALTO_PADRAO   = 1;

    // Ceiling log2, never below 1 so it can size a vector directly.
    function automatic int clog2w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/driver_matriz_scan_divisor.sv
// Scan prescaler: free-running counter with a one-clock tick on each wrap.
module divisor_tick
    import driver_matriz_pkg::*;
#(
    parameter int DIV_BITS = DIV_BITS_PADRAO
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    logic [DIV_BITS-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = &cnt_q;

endmodule

// File: rtl/driver_matriz_scan.sv
// Row-scanned LED matrix driver: double-buffered frame store, PWM brightness
// inside each row slot and forced blanking after every row change.
module driver_matriz_scan
    import driver_matriz_pkg::*;
#(
    parameter int LINHAS            = LINHAS_PADRAO,
    parameter int COLUNAS           = COLUNAS_PADRAO,
    parameter int DIV_BITS          = DIV_BITS_PADRAO,
    parameter int BRILHO_BITS       = BRILHO_BITS_PADRAO,
    parameter int BLANK_CICLOS      = BLANK_CICLOS_PADRAO,
    parameter int LINHA_ATIVO_ALTO  = ATIVO_ALTO_PADRAO,
    parameter int COLUNA_ATIVO_ALTO = ATIVO_ALTO_PADRAO
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [clog2w(LINHAS)-1:0] wr_linha,
    input  logic [COLUNAS-1:0]        wr_dado,
    input  logic                      troca_req,
    input  logic [BRILHO_BITS-1:0]    brilho,
    output logic                      troca_ack,
    output logic                      fim_quadro,
    output logic [LINHAS-1:0]         linhas,
    output logic [COLUNAS-1:0]        colunas
);
    localparam int RW = clog2w(LINHAS);
    localparam int BW = clog2w(BLANK_CICLOS);
    localparam logic [RW-1:0]          ULTIMA    = RW'(LINHAS - 1);
    localparam logic [BRILHO_BITS-1:0] FASE_MAX  = '1;
    localparam logic [BW-1:0]          BLANK_FIM = BW'(BLANK_CICLOS - 1);
    localparam logic [LINHAS-1:0]      UM_LINHA  = LINHAS'(1);
    localparam logic [LINHAS-1:0]      LINHAS_OFF  = {LINHAS{(LINHA_ATIVO_ALTO == 0)}};
    localparam logic [COLUNAS-1:0]     COLUNAS_OFF = {COLUNAS{(COLUNA_ATIVO_ALTO == 0)}};

    logic                                tick;
    logic [1:0][LINHAS-1:0][COLUNAS-1:0] mem_q;
    logic [BRILHO_BITS-1:0]              fase_q, fase_d;
    logic [BRILHO_BITS-1:0]              brilho_q, brilho_d;
    logic [RW-1:0]                       linha_q, linha_d;
    logic [BW-1:0]                       blank_q, blank_d;
    estado_t                             estado_q, estado_d;
    logic                                banco_q, banco_d;
    logic                                pend_q, pend_d;
    logic                                primeiro_q;
    logic                                fim_slot, fim_quadro_d, troca_d, wr_ok;
    logic [COLUNAS-1:0]                  padrao, colunas_d;
    logic [LINHAS-1:0]                   linhas_d;
    logic                                troca_ack_q, fim_quadro_q;
    logic [LINHAS-1:0]                   linhas_q;
    logic [COLUNAS-1:0]                  colunas_q;

    divisor_tick #(
        .DIV_BITS (DIV_BITS)
    ) u_divisor (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    assign wr_ok = wr_en && ({1'b0, wr_linha} < (RW + 1)'(LINHAS));

    always_comb begin
        fim_slot     = tick && (fase_q == FASE_MAX);
        fim_quadro_d = fim_slot && (linha_q == ULTIMA);
        troca_d      = fim_quadro_d && (pend_q || troca_req);

        fase_d   = tick ? fase_q + 1'b1 : fase_q;
        linha_d  = linha_q;
        if (fim_slot) begin
            linha_d = (linha_q == ULTIMA) ? '0 : linha_q + 1'b1;
        end
        banco_d  = troca_d ? ~banco_q : banco_q;
        pend_d   = troca_d ? 1'b0 : (troca_req ? 1'b1 : pend_q);
        brilho_d = (fim_slot || primeiro_q) ? brilho : brilho_q;

        estado_d = estado_q;
        blank_d  = blank_q;
        if (fim_slot) begin
            blank_d  = '0;
            estado_d = (BLANK_CICLOS == 0) ? ACESO : APAGADO;
        end else if (estado_q == APAGADO) begin
            if (BLANK_CICLOS == 0 || blank_q == BLANK_FIM) begin
                estado_d = ACESO;
            end else begin
                blank_d = blank_q + 1'b1;
            end
        end

        // On a swap edge the incoming write lands in the bank that becomes front.
        if (troca_d && wr_ok && (wr_linha == linha_d)) begin
            padrao = wr_dado;
        end else begin
            padrao = mem_q[banco_d][linha_d];
        end

        linhas_d  = '0;
        colunas_d = '0;
        if (estado_d == ACESO) begin
            linhas_d = UM_LINHA << linha_d;
            if (fase_d < brilho_d) begin
                colunas_d = padrao;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fase_q       <= '0;
            brilho_q     <= '0;
            linha_q      <= '0;
            blank_q      <= '0;
            estado_q     <= APAGADO;
            banco_q      <= 1'b0;
            pend_q       <= 1'b0;
            primeiro_q   <= 1'b1;
            troca_ack_q  <= 1'b0;
            fim_quadro_q <= 1'b0;
            linhas_q     <= LINHAS_OFF;
            colunas_q    <= COLUNAS_OFF;
        end else begin
            fase_q       <= fase_d;
            brilho_q     <= brilho_d;
            linha_q      <= linha_d;
            blank_q      <= blank_d;
            estado_q     <= estado_d;
            banco_q      <= banco_d;
            pend_q       <= pend_d;
            primeiro_q   <= 1'b0;
            troca_ack_q  <= troca_d;
            fim_quadro_q <= fim_quadro_d;
            linhas_q     <= linhas_d ^ LINHAS_OFF;
            colunas_q    <= colunas_d ^ COLUNAS_OFF;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q <= '0;
        end else if (wr_ok) begin
            mem_q[~banco_q][wr_linha] <= wr_dado;
        end
    end

    assign troca_ack  = troca_ack_q;
    assign fim_quadro = fim_quadro_q;
    assign linhas     = linhas_q;
    assign colunas    = colunas_q;

endmodule

// File: tb/tb_driver_matriz_scan.sv
// Three driver configurations share one stimulus stream and are checked every
// cycle against a time-indexed reference model of the scan.
module tb_driver_matriz_scan;

    logic       clock;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_linha;
    logic [7:0] wr_dado;
    logic       troca_req;
    logic [1:0] brilho;

    logic       ack_a, fim_a, ack_b, fim_b, ack_c, fim_c;
    logic [7:0] lin_a, col_a, lin_b, col_b, col_c;
    logic [4:0] lin_c;

    int checks = 0;
    int errors = 0;

    // Model configuration: rows, blanking clocks, row/column active-high.
    int L  [3] = '{8, 8, 5};
    int BL [3] = '{2, 0, 1};
    int LA [3] = '{1, 0, 1};
    int CA [3] = '{1, 0, 1};

    int         n;
    int         bs;
    logic [7:0] mem_m [3][2][8];
    logic       sel [3];
    logic       pend [3];
    logic [7:0] esp_lin [3], esp_col [3];
    logic       esp_fim [3], esp_ack [3];
    logic [7:0] obs_lin [3], obs_col [3];
    logic       obs_fim [3], obs_ack [3];

    assign obs_lin[0] = lin_a;
    assign obs_lin[1] = lin_b;
    assign obs_lin[2] = {3'b000, lin_c};
    assign obs_col[0] = col_a;
    assign obs_col[1] = col_b;
    assign obs_col[2] = col_c;
    assign obs_fim[0] = fim_a;
    assign obs_fim[1] = fim_b;
    assign obs_fim[2] = fim_c;
    assign obs_ack[0] = ack_a;
    assign obs_ack[1] = ack_b;
    assign obs_ack[2] = ack_c;

    driver_matriz_scan #(
        .LINHAS(8), .COLUNAS(8), .DIV_BITS(2), .BRILHO_BITS(2), .BLANK_CICLOS(2),
        .LINHA_ATIVO_ALTO(1), .COLUNA_ATIVO_ALTO(1)
    ) dut_a (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_linha(wr_linha),
        .wr_dado(wr_dado), .troca_req(troca_req), .brilho(brilho),
        .troca_ack(ack_a), .fim_quadro(fim_a), .linhas(lin_a), .colunas(col_a)
    );

    driver_matriz_scan #(
        .LINHAS(8), .COLUNAS(8), .DIV_BITS(2), .BRILHO_BITS(2), .BLANK_CICLOS(0),
        .LINHA_ATIVO_ALTO(0), .COLUNA_ATIVO_ALTO(0)
    ) dut_b (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_linha(wr_linha),
        .wr_dado(wr_dado), .troca_req(troca_req), .brilho(brilho),
        .troca_ack(ack_b), .fim_quadro(fim_b), .linhas(lin_b), .colunas(col_b)
    );

    driver_matriz_scan #(
        .LINHAS(5), .COLUNAS(8), .DIV_BITS(2), .BRILHO_BITS(2), .BLANK_CICLOS(1),
        .LINHA_ATIVO_ALTO(1), .COLUNA_ATIVO_ALTO(1)
    ) dut_c (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_linha(wr_linha),
        .wr_dado(wr_dado), .troca_req(troca_req), .brilho(brilho),
        .troca_ack(ack_c), .fim_quadro(fim_c), .linhas(lin_c), .colunas(col_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        assert (obs === esp) else begin
            errors++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, esp);
        end
    endtask

    task automatic esperado_inativo();
        for (int k = 0; k < 3; k++) begin
            esp_lin[k] = (LA[k] != 0) ? 8'h00 : 8'((1 << L[k]) - 1);
            esp_col[k] = (CA[k] != 0) ? 8'h00 : 8'hFF;
            esp_fim[k] = 1'b0;
            esp_ack[k] = 1'b0;
        end
    endtask

    task automatic modelo_reset();
        n  = 0;
        bs = 0;
        for (int k = 0; k < 3; k++) begin
            sel[k]  = 1'b0;
            pend[k] = 1'b0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 8; r++) mem_m[k][b][r] = 8'h00;
        end
        esperado_inativo();
    endtask

    // n = clock edges since reset release; row, phase and blanking follow from it.
    task automatic modelo_avanca();
        int         row, fase;
        logic       aceso, fronteira, troca;
        logic [2:0] ri;
        logic [7:0] el, ec;
        n++;
        if (n == 1 || (n % 16) == 0) bs = int'(brilho);
        for (int k = 0; k < 3; k++) begin
            if (wr_en && int'(wr_linha) < L[k]) mem_m[k][!sel[k]][wr_linha] = wr_dado;
            fronteira = ((n % (16 * L[k])) == 0);
            troca     = fronteira && (pend[k] || troca_req);
            if (troca) begin
                sel[k]  = !sel[k];
                pend[k] = 1'b0;
            end else if (troca_req) begin
                pend[k] = 1'b1;
            end
            row   = (n / 16) % L[k];
            fase  = (n / 4) % 4;
            ri    = 3'(row);
            aceso = (n % 16) >= BL[k];
            el    = aceso ? (8'd1 << row) : 8'd0;
            ec    = (aceso && fase < bs) ? mem_m[k][sel[k]][ri] : 8'd0;
            if (LA[k] == 0) el = el ^ 8'((1 << L[k]) - 1);
            if (CA[k] == 0) ec = ~ec;
            esp_lin[k] = el;
            esp_col[k] = ec;
            esp_fim[k] = fronteira;
            esp_ack[k] = troca;
        end
    endtask

    task automatic confere_tudo();
        for (int k = 0; k < 3; k++) begin
            confere($sformatf("linhas%0d", k), obs_lin[k], esp_lin[k]);
            confere($sformatf("colunas%0d", k), obs_col[k], esp_col[k]);
            confere($sformatf("fim_quadro%0d", k), obs_fim[k], esp_fim[k]);
            confere($sformatf("troca_ack%0d", k), obs_ack[k], esp_ack[k]);
        end
    endtask

    task automatic passo(input logic we, input logic [2:0] wl, input logic [7:0] wd,
                         input logic tr, input logic [1:0] br);
        wr_en     = we;
        wr_linha  = wl;
        wr_dado   = wd;
        troca_req = tr;
        brilho    = br;
        @(posedge clock);
        #1;
        modelo_avanca();
        confere_tudo();
    endtask

    task automatic passo_aleatorio();
        logic       we, tr;
        logic [2:0] wl;
        logic [7:0] wd;
        logic [1:0] br;
        we = ($urandom_range(0, 2) == 0);
        wl = 3'($urandom_range(0, 7));
        wd = 8'($urandom);
        tr = ($urandom_range(0, 39) == 0);
        br = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : brilho;
        passo(we, wl, wd, tr, br);
    endtask

    initial begin
        logic found;
        wr_en = 0; wr_linha = 0; wr_dado = 0; troca_req = 0; brilho = 0;
        reset = 1'b1;
        n = 0;
        #1 reset = 1'b0;
        #1;
        esperado_inativo();
        confere_tudo();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        modelo_reset();
        confere_tudo();

        // Row 3 = A5 into the back bank, then a single swap request.
        passo(1'b1, 3'd3, 8'hA5, 1'b0, 2'd3);
        passo(1'b0, 3'd0, 8'h00, 1'b1, 2'd3);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            passo(1'b0, 3'd0, 8'h00, 1'b0, 2'd3);
            if (ack_a) found = 1'b1;
        end
        confere("ack_seen", found, 1'b1);
        confere("fim_with_ack", fim_a, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            passo(1'b0, 3'd0, 8'h00, 1'b0, 2'd3);
            if ((n / 16) % 8 == 3 && (n % 16) >= 2 && (n / 4) % 4 < 3) found = 1'b1;
        end
        confere("row3_reached", found, 1'b1);
        confere("row3_linhas", lin_a, 8'h08);
        confere("row3_colunas", col_a, 8'hA5);

        // brilho=0 keeps every column dark for a whole frame.
        repeat (16) passo(1'b0, 3'd0, 8'h00, 1'b0, 2'd0);
        for (int i = 0; i < 128; i++) begin
            passo(1'b0, 3'd0, 8'h00, 1'b0, 2'd0);
            confere("dark_colunas", col_a, 8'h00);
        end

        repeat (2500) passo_aleatorio();

        // Asynchronous reset in the middle of row 6.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            passo_aleatorio();
            if ((n / 16) % 8 == 6 && (n % 16) >= 2) found = 1'b1;
        end
        confere("row6_reached", found, 1'b1);
        confere("row6_linhas", lin_a, 8'h40);
        #1 reset = 1'b0;
        #1;
        esperado_inativo();
        confere_tudo();
        repeat (3) begin
            @(posedge clock);
            #1;
            confere_tudo();
        end
        reset = 1'b1;
        modelo_reset();
        confere_tudo();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            passo(1'b0, 3'd0, 8'h00, 1'b0, 2'd3);
            if (lin_a != 8'h00) found = 1'b1;
        end
        confere("first_row_seen", found, 1'b1);
        confere("first_row", lin_a, 8'h01);

        // Both banks must read back as zero after reset.
        for (int i = 0; i < 300; i++) passo(1'b0, 3'd0, 8'h00, (i == 5), 2'd3);
        repeat (400) passo_aleatorio();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/driver_matriz_scan.md
DRIVER_MATRIZ_SCAN -- requirements
Module: driver_matriz_scan

Interface
REQ-001 Parameter LINHAS, default 8: number of matrix rows (2..32, any integer).
REQ-002 Parameter COLUNAS, default 8: number of matrix columns (1..32).
REQ-003 Parameter DIV_BITS, default 8: width of the scan prescaler; one tick every 2^DIV_BITS clocks.
REQ-004 Parameter BRILHO_BITS, default 4: brightness resolution; one row slot is 2^BRILHO_BITS ticks.
REQ-005 Parameter BLANK_CICLOS, default 2: clocks of forced blanking after each row change (0 allowed).
REQ-006 Parameters LINHA_ATIVO_ALTO and COLUNA_ATIVO_ALTO, default 1: asserted level of the row and column pins (0 = active-low).
REQ-007 clock  input  1  system clock; all logic on the rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 wr_en  input  1  write strobe into the back buffer.
REQ-010 wr_linha  input  clog2(LINHAS)  row index for the write.
REQ-011 wr_dado  input  COLUNAS  row pattern; bit i lights column i.
REQ-012 troca_req  input  1  request a buffer swap at the next frame boundary.
REQ-013 brilho  input  BRILHO_BITS  global brightness (0 = dark).
REQ-014 troca_ack  output  1  one-cycle pulse when a swap takes effect.
REQ-015 fim_quadro  output  1  one-cycle pulse at every frame boundary.
REQ-016 linhas  output  LINHAS  row drive pins, polarity per LINHA_ATIVO_ALTO.
REQ-017 colunas  output  COLUNAS  column drive pins, polarity per COLUNA_ATIVO_ALTO.

Function
REQ-018 Storage: two banks of LINHAS x COLUNAS bits. A bank-select bit marks one bank as front (displayed); the other is back (written).
REQ-019 Write: on a clock edge with wr_en=1, wr_dado is stored in back-bank row wr_linha. Writes with wr_linha>=LINHAS are ignored. Front-bank contents never change because of a write.
REQ-020 Tick: the prescaler counts 0..2^DIV_BITS-1 and wraps. The tick is high for exactly one clock, on the wrap.
REQ-021 Row slot: the row counter holds one row for 2^BRILHO_BITS ticks. A phase counter 0..2^BRILHO_BITS-1 advances on each tick. The row counter then advances and wraps from LINHAS-1 to 0, including for LINHAS that is not a power of two.
REQ-022 Brightness: brilho is sampled at the start of each row slot. Columns are driven only while phase < sampled brilho, so duty = brilho/2^BRILHO_BITS. A brilho change mid-slot takes effect at the next slot.
REQ-023 FSM with states APAGADO and ACESO:
- Entering a new row goes to APAGADO, which holds all row and column pins inactive for BLANK_CICLOS clocks and then goes to ACESO.
- With BLANK_CICLOS=0, the FSM goes directly to ACESO.
- In ACESO exactly one row pin is asserted, and colunas = front-bank pattern of the current row, gated per REQ-022.
REQ-024 Frame boundary: the edge on which row LINHAS-1 completes its slot.
- fim_quadro is high for the following clock.
REQ-025 Swap: troca_req=1 on any edge sets a pending flag.
- At a frame boundary with the flag set, or with troca_req=1 on that same edge, the bank select toggles and the flag clears.
- troca_ack is high for the clock after that edge, coincident with fim_quadro.
- Repeated requests within one frame produce one swap.
REQ-026 Write on the swap edge: the write lands in the bank that was back before the edge, which becomes front.
REQ-027 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-028 While reset=0:
- linhas and colunas sit at their inactive levels.
- troca_ack=0 and fim_quadro=0.
- Prescaler, phase counter, row counter, bank select and pending flag are 0.
- The FSM is in APAGADO, and both banks are cleared to 0.
REQ-029 Reset asserted mid-frame forces outputs inactive immediately, without waiting for a clock. After release, scanning restarts at row 0 with a full blanking interval.

Structure
REQ-030 Shared package driver_matriz_pkg holds the FSM state enumeration, the default parameter constants and a ceiling-log2 width function.
REQ-031 One sub-module, divisor_tick (parameter DIV_BITS; ports clock, reset, tick), implements REQ-020. All other logic stays in driver_matriz_scan.

Verification
REQ-032 The bench shall cover the following directed scenarios:
- Reset, DIV_BITS=2, BRILHO_BITS=2, defaults otherwise: while reset=0, linhas=8'h00 and colunas=8'h00. With LINHA_ATIVO_ALTO=0, linhas=8'hFF.
- Write row 3 = 8'hA5 to the back bank, troca_req one cycle: within one frame troca_ack and fim_quadro pulse together. During row 3 ACESO, linhas=8'h08 and colunas=8'hA5.
- brilho=2, BRILHO_BITS=2: colunas is asserted for exactly 2 of the 4 ticks per slot. brilho=0 gives colunas all-inactive for the whole frame.
- BLANK_CICLOS=2: at every row change, all pins are inactive for exactly 2 clocks before the next row asserts.
- LINHAS=5: the row sequence is 0,1,2,3,4,0. fim_quadro pulses once every 5 slots.
- Reset asserted in the middle of row 6: outputs go inactive before the next clock edge. After release, the first asserted row is 0 and both banks read 0.
